// File: rtl/fdct8_1d_core.sv
// Forward 8-point DCT-VIII, 1-D: serial sample load, one shared 2-stage
// signed multiplier, single accumulator, round/shift/saturate per coefficient.
module fdct8_1d_core #(
   parameter int unsigned IN_W   = 16,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned SHIFT  = 4
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   localparam int unsigned PROD_W = COEF_W + IN_W;
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

   // DCT8 basis, row-major M[k][n] addressed by {k, n}
   localparam logic signed [7:0] DCT8 [64] = '{
      8'sd86,  8'sd85,  8'sd78,  8'sd71,  8'sd60,  8'sd46,  8'sd32,  8'sd17,
      8'sd85,  8'sd60,  8'sd17, -8'sd32, -8'sd71, -8'sd86, -8'sd78, -8'sd46,
      8'sd78,  8'sd17, -8'sd60, -8'sd86, -8'sd46,  8'sd32,  8'sd85,  8'sd71,
      8'sd71, -8'sd32, -8'sd86, -8'sd17,  8'sd78,  8'sd60, -8'sd46, -8'sd85,
      8'sd60, -8'sd71, -8'sd46,  8'sd78,  8'sd32, -8'sd85, -8'sd17,  8'sd86,
      8'sd46, -8'sd86,  8'sd32,  8'sd60, -8'sd85,  8'sd17,  8'sd71, -8'sd78,
      8'sd32, -8'sd78,  8'sd85, -8'sd46, -8'sd17,  8'sd71, -8'sd86,  8'sd60,
      8'sd17, -8'sd46,  8'sd71, -8'sd85,  8'sd86, -8'sd78,  8'sd60, -8'sd32
   };

   typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

   state_t                    state;
   logic [2:0]                cnt_in;
   logic [3:0]                cyc;
   logic [2:0]                k;
   logic signed [ACC_W-1:0]   acc;
   logic signed [IN_W-1:0]    xs [8];
   logic signed [COEF_W-1:0]  s1_c;
   logic signed [IN_W-1:0]    s1_x;
   logic                      s1_v;
   logic signed [PROD_W-1:0]  s2_p;
   logic                      s2_v;
   logic signed [ACC_W-1:0]   rsum;
   logic signed [ACC_W-1:0]   shf;
   logic signed [ACC_W-1:0]   sat_c;

   // Sample store, written only while loading
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < 8; i++) xs[i] <= '0;
      end else if (state == LOAD && in_valid && in_ready) begin
         xs[cnt_in] <= in_data;
      end
   end

   // Two-stage multiplier; enabled only during CALC, issue slots are cyc 0..7
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_c <= '0;
         s1_x <= '0;
         s1_v <= 1'b0;
         s2_p <= '0;
         s2_v <= 1'b0;
      end else if (state == CALC) begin
         s1_c <= COEF_W'(DCT8[{k, cyc[2:0]}]);
         s1_x <= xs[cyc[2:0]];
         s1_v <= ~cyc[3];
         s2_p <= PROD_W'(s1_c) * PROD_W'(s1_x);
         s2_v <= s1_v;
      end
   end

   // Round half up, arithmetic shift, clamp to the output range
   always_comb begin
      rsum  = acc + RND;
      shf   = rsum >>> SHIFT;
      sat_c = shf;
      if (shf > OMAX)
         sat_c = OMAX;
      else if (shf < OMIN)
         sat_c = OMIN;
   end

   // Control FSM with accumulator and registered handshake outputs
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= LOAD;
         in_ready  <= 1'b0;
         cnt_in    <= '0;
         cyc       <= '0;
         k         <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  cnt_in <= cnt_in + 3'd1;
                  if (cnt_in == 3'd7) begin
                     state    <= CALC;
                     in_ready <= 1'b0;
                     cyc      <= '0;
                     k        <= '0;
                     acc      <= '0;
                  end
               end
            end
            CALC: begin
               cyc <= cyc + 4'd1;
               if (s2_v)
                  acc <= acc + ACC_W'(s2_p);
               if (cyc == 4'd10) begin
                  out_data  <= OUT_W'(sat_c);
                  out_valid <= 1'b1;
                  out_last  <= (k == 3'd7);
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (k == 3'd7) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                     cnt_in   <= '0;
                  end else begin
                     k     <= k + 3'd1;
                     acc   <= '0;
                     cyc   <= '0;
                     state <= CALC;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fdct8_1d_core.sv
// Scoreboard bench for fdct8_1d_core: directed blocks with hand-computed coefficients.
module tb_fdct8_1d_core;

   logic               ap_clk   = 1'b0;
   logic               ap_rst_n = 1'b1;
   logic signed [15:0] in_data  = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               out_last;

   fdct8_1d_core dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int data;
      bit last;
   } exp_t;

   exp_t exp_q [$];
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   hs_cnt  = 0;
   int   nedge   = 0;
   int   last_ev = 0;
   bit   prev_valid = 1'b0;

   int x_imp  [8] = '{64, 0, 0, 0, 0, 0, 0, 0};
   int y_imp  [8] = '{344, 340, 312, 284, 240, 184, 128, 68};
   int x_one  [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
   int y_one  [8] = '{30, -9, 6, -4, 2, -1, 1, 0};
   int x_pmax [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
   int y_pmax [8] = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -14336};
   int x_nmax [8] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
   int y_nmax [8] = '{-32768, 32767, -32768, 32767, -32768, 32767, -32768, 14336};
   int x_diff [8] = '{16, -16, 0, 0, 0, 0, 0, 0};
   int y_diff [8] = '{1, 25, 61, 103, 131, 132, 110, 63};
   int x_x7   [8] = '{0, 0, 0, 0, 0, 0, 0, 32};
   int y_x7   [8] = '{34, -92, 142, -170, 172, -156, 120, -64};

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Monitor: latency of each out_valid rise and scoreboard pop on handshake
   always @(negedge ap_clk) begin
      nedge++;
      if (!ap_rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (in_valid && in_ready)
            last_ev = nedge;
         if (out_valid && !prev_valid)
            chk("latency", nedge - last_ev, 12);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got data %0d, expected no output", out_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", int'(out_data), e.data);
               chk("out_last", int'(out_last), int'(e.last));
            end
            last_ev = nedge;
            hs_cnt++;
         end
         prev_valid = out_valid;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the sample was taken
   task automatic drive_sample(input int v);
      int t = 0;
      in_data  = 16'(v);
      in_valid = 1'b1;
      @(negedge ap_clk);
      while (!in_ready && t < 200) begin
         @(negedge ap_clk);
         t++;
      end
      if (!in_ready) timeout("in_ready_wait");
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(input int x[8], input int y[8], input int gap, input bit push);
      if (push) begin
         for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = y[i];
            e.last = (i == 7);
            exp_q.push_back(e);
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive_sample(x[i]);
         if (i < 7) begin
            for (int g = 0; g < gap; g++) begin
               @(negedge ap_clk);
               chk("in_ready_gap", int'(in_ready), 1);
               @(posedge ap_clk);
               #1;
            end
         end
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge ap_clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         timeout("drain");
         exp_q.delete();
      end
      @(negedge ap_clk);
      chk("in_ready_after_block", int'(in_ready), 1);
      @(posedge ap_clk);
      #1;
   endtask

   // Stall y[3] for several cycles while poking in_valid
   task automatic bp_test(input int y3);
      int base = hs_cnt;
      int t = 0;
      while (hs_cnt < base + 3 && t < 200) begin
         @(negedge ap_clk);
         t++;
      end
      @(posedge ap_clk);
      #1;
      out_ready = 1'b0;
      t = 0;
      @(negedge ap_clk);
      while (!out_valid && t < 50) begin
         @(negedge ap_clk);
         t++;
      end
      if (!out_valid) timeout("bp_valid_wait");
      for (int i = 0; i < 5; i++) begin
         @(posedge ap_clk);
         #1;
         in_valid = 1'b1;
         in_data  = 16'(12345 + i);
         @(negedge ap_clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_out_data", int'(out_data), y3);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      @(posedge ap_clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      #1 ap_rst_n = 1'b0;
      repeat (3) @(negedge ap_clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'(out_data), 0);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("in_ready_after_rst", int'(in_ready), 1);

      send_block(x_imp, y_imp, 0, 1'b1);
      wait_drain();

      send_block(x_one, y_one, 0, 1'b1);
      bp_test(y_one[3]);
      wait_drain();

      send_block(x_pmax, y_pmax, 0, 1'b1);
      wait_drain();
      send_block(x_nmax, y_nmax, 0, 1'b1);
      wait_drain();

      send_block(x_imp, y_imp, 2, 1'b1);
      wait_drain();

      send_block(x_diff, y_diff, 0, 1'b1);
      wait_drain();

      // Abort a block mid-CALC, then verify a clean block follows
      send_block(x_pmax, y_pmax, 0, 1'b0);
      repeat (6) @(posedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("rst_calc_out_valid", int'(out_valid), 0);
      chk("rst_calc_in_ready", int'(in_ready), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      send_block(x_x7, y_x7, 0, 1'b1);
      wait_drain();

      // Abort while a coefficient is being presented
      out_ready = 1'b0;
      send_block(x_imp, y_imp, 0, 1'b0);
      t = 0;
      @(negedge ap_clk);
      while (!out_valid && t < 50) begin
         @(negedge ap_clk);
         t++;
      end
      chk("held_out_valid", int'(out_valid), 1);
      chk("held_out_data", int'(out_data), 344);
      @(posedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("rst_out_out_valid", int'(out_valid), 0);
      chk("rst_out_out_data", int'(out_data), 0);
      chk("rst_out_out_last", int'(out_last), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      out_ready = 1'b1;
      send_block(x_diff, y_diff, 0, 1'b1);
      wait_drain();

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
